program_loader: RTL and testbench

- Byte-stream boot loader that writes the instruction memory the MIPS core fetches from.
- It takes framed bytes from a serial front end, assembles them into 32-bit words and issues word writes to the program-memory write port.
- It holds the processor in reset until a complete, checksum-verified image has been written.
- It is the writer side of the program-memory interface, which the core only reads.

---
 rtl/program_loader_pkg.sv | 32 +++
 rtl/program_loader_if.sv | 26 ++
 rtl/program_loader_word_assembler.sv | 32 +++
 rtl/program_loader.sv | 204 ++++++++++++++++++++
 tb/tb_program_loader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM states, error codes,
// frame constants and small arithmetic helpers.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    function automatic logic [7:0] csum_next(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write / boot status signals of the loader.
interface program_loader_if;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        restart_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        error_o;
    logic [1:0]  error_code_o;
    logic [15:0] words_loaded_o;

    modport slave (
        input  byte_valid_i, byte_i, restart_i,
        output mem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o,
               done_o, error_o, error_code_o, words_loaded_o
    );

    modport master (
        output byte_valid_i, byte_i, restart_i,
        input  mem_we_o, mem_addr_o, mem_wdata_o, cpu_hold_o,
               done_o, error_o, error_code_o, words_loaded_o
    );
endinterface

// File: rtl/program_loader_word_assembler.sv
// Shifts bytes in little-endian order; the full word is presented together
// with the fourth byte so the caller can register it on that same edge.
module program_loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_full
);

    logic [23:0] shift_r;
    logic [1:0]  cnt_r;

    assign word      = {byte_in, shift_r};
    assign word_full = shift_en && (cnt_r == 2'd3);

    // Byte shift register and position counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r <= 24'd0;
            cnt_r   <= 2'd0;
        end else if (clear) begin
            cnt_r   <= 2'd0;
        end else if (shift_en) begin
            shift_r <= {byte_in, shift_r[23:8]};
            cnt_r   <= cnt_r + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses framed bytes, writes words to program memory and
// releases the core only after a checksum-verified image has been loaded.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          MEMORY_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDRESS   = 32'h0040_0000,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   bus
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]     DEPTH_W  = 16'(MEMORY_DEPTH);

    state_e      state_r, state_nxt_s;
    err_code_e   err_code_nxt_s;
    logic [15:0] len_r, len_full_s, words_r;
    logic [7:0]  csum_r;
    logic [TW-1:0] tmo_r;
    logic        tmo_hit_s, active_s;
    logic        frame_start_s, restart_clr_s, write_word_s, csum_add_s;
    logic        shift_en_s, asm_clear_s, word_full_s;
    logic [31:0] word_s;
    logic        mem_we_r, done_r, error_r, cpu_hold_r;
    logic [31:0] mem_addr_r, mem_wdata_r;
    logic [1:0]  error_code_r;

    assign len_full_s  = {bus.byte_i, len_r[7:0]};
    assign active_s    = state_r inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK};
    assign tmo_hit_s   = !bus.byte_valid_i && (tmo_r == TMO_LAST);
    assign shift_en_s  = (state_r == ST_DATA) && bus.byte_valid_i;
    assign asm_clear_s = (state_r != ST_DATA);

    program_loader_word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear_s),
        .shift_en  (shift_en_s),
        .byte_in   (bus.byte_i),
        .word      (word_s),
        .word_full (word_full_s)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Next-state and per-cycle control strobes; a byte always beats a timeout
    always_comb begin
        state_nxt_s    = state_r;
        err_code_nxt_s = ERR_NONE;
        frame_start_s  = 1'b0;
        restart_clr_s  = 1'b0;
        write_word_s   = 1'b0;
        csum_add_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.byte_valid_i && (bus.byte_i == SYNC_BYTE)) begin
                    state_nxt_s   = ST_LEN_LO;
                    frame_start_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LEN_LO: begin
                if (bus.byte_valid_i) begin
                    state_nxt_s = ST_LEN_HI;
                end else if (tmo_hit_s) begin
                    state_nxt_s    = ST_ERROR;
                    err_code_nxt_s = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = ST_LEN_LO;
                end
            end
            ST_LEN_HI: begin
                if (bus.byte_valid_i) begin
                    if (len_full_s > DEPTH_W) begin
                        state_nxt_s    = ST_ERROR;
                        err_code_nxt_s = ERR_LEN;
                    end else if (len_full_s == 16'd0) begin
                        state_nxt_s = ST_CHECK;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s    = ST_ERROR;
                    err_code_nxt_s = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = ST_LEN_HI;
                end
            end
            ST_DATA: begin
                if (bus.byte_valid_i) begin
                    csum_add_s = 1'b1;
                    if (word_full_s) begin
                        write_word_s = 1'b1;
                        if ((words_r + 16'd1) == len_r) state_nxt_s = ST_CHECK;
                        else                            state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s    = ST_ERROR;
                    err_code_nxt_s = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (bus.byte_valid_i) begin
                    if (bus.byte_i == csum_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s    = ST_ERROR;
                        err_code_nxt_s = ERR_CSUM;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt_s    = ST_ERROR;
                    err_code_nxt_s = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = ST_CHECK;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (bus.restart_i) begin
                    state_nxt_s   = ST_IDLE;
                    restart_clr_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Inter-byte timeout counter, only running while a frame is open
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                              tmo_r <= {TW{1'b0}};
        else if (active_s && !bus.byte_valid_i && !tmo_hit_s)   tmo_r <= tmo_r + TW'(1);
        else                                                     tmo_r <= {TW{1'b0}};
    end

    // Frame bookkeeping: length, running checksum and word count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_r   <= 16'd0;
            csum_r  <= 8'd0;
            words_r <= 16'd0;
        end else begin
            if (state_r == ST_LEN_LO && bus.byte_valid_i)      len_r <= {8'd0, bus.byte_i};
            else if (state_r == ST_LEN_HI && bus.byte_valid_i) len_r <= len_full_s;

            if (frame_start_s || restart_clr_s) csum_r <= 8'd0;
            else if (csum_add_s)                csum_r <= csum_next(csum_r, bus.byte_i);

            if (frame_start_s || restart_clr_s) words_r <= 16'd0;
            else if (write_word_s)              words_r <= words_r + 16'd1;
        end
    end

    // Registered memory write port and boot status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we_r     <= 1'b0;
            mem_addr_r   <= BASE_ADDRESS;
            mem_wdata_r  <= 32'd0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            cpu_hold_r   <= 1'b1;
            error_code_r <= 2'd0;
        end else begin
            mem_we_r <= write_word_s;
            if (write_word_s) begin
                mem_addr_r  <= word_addr(BASE_ADDRESS, words_r);
                mem_wdata_r <= word_s;
            end
            done_r     <= (state_nxt_s == ST_DONE);
            error_r    <= (state_nxt_s == ST_ERROR);
            cpu_hold_r <= (state_nxt_s != ST_DONE);
            if (restart_clr_s)
                error_code_r <= ERR_NONE;
            else if (state_nxt_s == ST_ERROR && state_r != ST_ERROR)
                error_code_r <= err_code_nxt_s;
        end
    end

    assign bus.mem_we_o       = mem_we_r;
    assign bus.mem_addr_o     = mem_addr_r;
    assign bus.mem_wdata_o    = mem_wdata_r;
    assign bus.cpu_hold_o     = cpu_hold_r;
    assign bus.done_o         = done_r;
    assign bus.error_o        = error_r;
    assign bus.error_code_o   = error_code_r;
    assign bus.words_loaded_o = words_r;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_program_loader;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 256;
    localparam int          TMO   = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    program_loader_if ifc ();

    always #5 clk = ~clk;

    program_loader #(
        .MEMORY_DEPTH   (DEPTH),
        .BASE_ADDRESS   (BASE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] cap_addr[$], cap_data[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [7:0]  frame[$];
    logic        exp_done;
    logic [1:0]  exp_code;
    int          exp_words;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Capture every memory write the loader issues
    always @(negedge clk) begin
        if (reset && ifc.mem_we_o) begin
            cap_addr.push_back(ifc.mem_addr_o);
            cap_data.push_back(ifc.mem_wdata_o);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        ifc.byte_valid_i = 1'b1;
        ifc.byte_i       = b;
        @(negedge clk);
        ifc.byte_valid_i = 1'b0;
        ifc.byte_i       = 8'h00;
    endtask

    task automatic do_restart();
        ifc.restart_i = 1'b1;
        @(negedge clk);
        ifc.restart_i = 1'b0;
    endtask

    task automatic send_frame(input int gap_max);
        foreach (frame[i]) begin
            send_byte(frame[i]);
            idle($urandom_range(gap_max, 0));
        end
    endtask

    task automatic check_status(input logic done, input logic [1:0] code, input int words);
        check_val("done_o", ifc.done_o, done);
        check_val("error_o", ifc.error_o, !done);
        check_val("error_code_o", ifc.error_code_o, code);
        check_val("cpu_hold_o", ifc.cpu_hold_o, !done);
        check_val("words_loaded_o", ifc.words_loaded_o, words);
    endtask

    // Reference: interpret the frame bytes directly from the frame format
    task automatic run_model();
        int i, len, sum;
        logic [31:0] w;
        logic [7:0]  b;
        exp_addr.delete();
        exp_data.delete();
        i = 0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        len = int'(frame[i+1]) + 256 * int'(frame[i+2]);
        if (len > DEPTH) begin
            exp_done = 1'b0; exp_code = 2'd1; exp_words = 0;
        end else begin
            sum = 0;
            for (int k = 0; k < len; k++) begin
                w = 32'd0;
                for (int j = 0; j < 4; j++) begin
                    b = frame[i + 3 + 4*k + j];
                    w = w | (32'(b) << (8*j));
                    sum += int'(b);
                end
                exp_addr.push_back(BASE + 32'(4*k));
                exp_data.push_back(w);
            end
            exp_words = len;
            if (int'(frame[i + 3 + 4*len]) == (sum % 256)) begin
                exp_done = 1'b1; exp_code = 2'd0;
            end else begin
                exp_done = 1'b0; exp_code = 2'd2;
            end
        end
    endtask

    task automatic check_writes();
        check_val("write_count", cap_addr.size(), exp_addr.size());
        if (cap_addr.size() == exp_addr.size()) begin
            foreach (exp_addr[k]) begin
                check_val("write_addr", cap_addr[k], exp_addr[k]);
                check_val("write_data", cap_data[k], exp_data[k]);
            end
        end
    endtask

    task automatic build_random_frame();
        int n, len, sum;
        logic [7:0] b;
        frame.delete();
        n = $urandom_range(3, 0);
        repeat (n) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            frame.push_back(b);
        end
        frame.push_back(8'hA5);
        if ($urandom_range(9, 0) == 0) len = $urandom_range(300, 257);
        else                           len = $urandom_range(4, 0);
        frame.push_back(8'(len));
        frame.push_back(8'(len >> 8));
        if (len > DEPTH) begin
            repeat (3) frame.push_back(8'($urandom));
        end else begin
            sum = 0;
            repeat (4*len) begin
                b = 8'($urandom);
                sum += int'(b);
                frame.push_back(b);
            end
            if ($urandom_range(2, 0) == 0) frame.push_back(8'(sum + $urandom_range(255, 1)));
            else                           frame.push_back(8'(sum));
        end
    endtask

    task automatic load_nominal(input logic [7:0] csum);
        logic [7:0] hdr[3];
        logic [7:0] dat[8];
        hdr = '{8'hA5, 8'h02, 8'h00};
        dat = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        foreach (hdr[i]) send_byte(hdr[i]);
        check_val("hold_during_load", ifc.cpu_hold_o, 1'b1);
        foreach (dat[i]) begin
            send_byte(dat[i]);
            if (i == 3 || i == 7) begin
                check_val("we_latency", ifc.mem_we_o, 1'b1);
                check_val("we_addr", ifc.mem_addr_o, (i == 3) ? 32'h0040_0000 : 32'h0040_0004);
                check_val("we_data", ifc.mem_wdata_o, (i == 3) ? 32'h1234_5678 : 32'hDEAD_BEEF);
            end else begin
                check_val("we_idle", ifc.mem_we_o, 1'b0);
            end
        end
        send_byte(csum);
        idle(2);
    endtask

    initial begin
        ifc.byte_valid_i = 1'b0;
        ifc.byte_i       = 8'h00;
        ifc.restart_i    = 1'b0;
        @(negedge clk);
        check_val("rst_we", ifc.mem_we_o, 1'b0);
        check_val("rst_addr", ifc.mem_addr_o, BASE);
        check_val("rst_wdata", ifc.mem_wdata_o, 32'd0);
        check_val("rst_hold", ifc.cpu_hold_o, 1'b1);
        check_val("rst_done", ifc.done_o, 1'b0);
        check_val("rst_error", ifc.error_o, 1'b0);
        check_val("rst_code", ifc.error_code_o, 2'd0);
        check_val("rst_words", ifc.words_loaded_o, 16'd0);
        reset = 1'b1;
        idle(2);

        // Nominal two-word image; data-byte sum is 0x4C
        cap_addr.delete(); cap_data.delete();
        load_nominal(8'h4C);
        check_val("nom_count", cap_addr.size(), 2);
        check_status(1'b1, 2'd0, 2);
        do_restart();
        check_val("restart_done", ifc.done_o, 1'b0);
        check_val("restart_hold", ifc.cpu_hold_o, 1'b1);
        check_val("restart_words", ifc.words_loaded_o, 16'd0);

        // Bad checksum
        load_nominal(8'h4D);
        check_status(1'b0, 2'd2, 2);
        do_restart();
        check_val("restart_error", ifc.error_o, 1'b0);
        check_val("restart_code", ifc.error_code_o, 2'd0);
        check_val("restart_words2", ifc.words_loaded_o, 16'd0);
        check_val("restart_hold2", ifc.cpu_hold_o, 1'b1);

        // Oversize length, rejected on the high length byte
        cap_addr.delete(); cap_data.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        check_status(1'b0, 2'd1, 0);
        send_byte(8'h11); send_byte(8'h22); idle(3);
        check_val("oversize_writes", cap_addr.size(), 0);
        do_restart();

        // Timeout mid-frame: still open after 15 idle cycles, error after 16
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11);
        idle(TMO - 1);
        check_val("tmo_not_yet", ifc.error_o, 1'b0);
        idle(1);
        check_status(1'b0, 2'd3, 0);
        check_val("tmo_writes", cap_addr.size(), 0);
        do_restart();

        // Noise followed by an empty image
        send_byte(8'h00); send_byte(8'hFF);
        check_val("noise_hold", ifc.cpu_hold_o, 1'b1);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle(2);
        check_status(1'b1, 2'd0, 0);
        check_val("empty_writes", cap_addr.size(), 0);
        do_restart();

        // Reset in the middle of the data phase, then a clean reload
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)));
        reset = 1'b0;
        #1;
        check_val("mid_rst_addr", ifc.mem_addr_o, BASE);
        check_val("mid_rst_wdata", ifc.mem_wdata_o, 32'd0);
        check_val("mid_rst_hold", ifc.cpu_hold_o, 1'b1);
        check_val("mid_rst_words", ifc.words_loaded_o, 16'd0);
        check_val("mid_rst_we", ifc.mem_we_o, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        cap_addr.delete(); cap_data.delete();
        load_nominal(8'h4C);
        check_val("reload_count", cap_addr.size(), 2);
        check_status(1'b1, 2'd0, 2);
        do_restart();

        // Randomized frames against the reference model
        for (int f = 0; f < 40; f++) begin
            build_random_frame();
            run_model();
            cap_addr.delete(); cap_data.delete();
            send_frame(4);
            idle(2);
            check_writes();
            check_status(exp_done, exp_code, exp_words);
            do_restart();
            check_val("rand_restart", ifc.error_o | ifc.done_o, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
